// File: rtl/uart_pkg.sv
// Shared UART definitions: baud table, receive FSM encoding and 16x oversample factor.
// The baud table is shared by the receiver and transmitter so both agree on rates.
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;
    localparam logic [2:0]  BAUD_SEL_DEFAULT = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_t;

    function automatic int unsigned baud_bps(input logic [2:0] sel);
        case (sel)
            3'd0:    return 9600;
            3'd1:    return 19200;
            3'd2:    return 38400;
            3'd3:    return 57600;
            default: return 115200;
        endcase
    endfunction

    // Clk cycles per oversample tick, truncated toward zero.
    function automatic logic [8:0] baud_div(input int unsigned clk_freq, input logic [2:0] sel);
        int unsigned d;
        d = clk_freq / (OVERSAMPLE * baud_bps(sel));
        return d[8:0];
    endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// 16x oversample tick strobe; the rate is captured on restart so it stays fixed for a whole frame.
module uart_rx_tick_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50000000
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       i_restart,
    input  logic [2:0] i_baud_set,
    output logic       o_tick
);

    logic [8:0] r_div;
    logic [8:0] r_cnt;
    logic [8:0] w_div_new;

    assign w_div_new = baud_div(CLK_FREQ, i_baud_set);

    // Down-counter: first tick lands DIV cycles after restart, then every DIV cycles.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_div <= baud_div(CLK_FREQ, BAUD_SEL_DEFAULT);
            r_cnt <= '0;
        end else if (i_restart) begin
            r_div <= w_div_new;
            r_cnt <= w_div_new - 9'd1;
        end else if (r_cnt == 9'd0) begin
            r_cnt <= r_div - 9'd1;
        end else begin
            r_cnt <= r_cnt - 9'd1;
        end
    end

    assign o_tick = (r_cnt == 9'd0) && !i_restart;

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver with 5-sample majority vote per bit.
//   state | meaning
//   IDLE  | waiting for synchronized 1->0 edge
//   START | voting on start bit; majority 1 is a glitch, back to IDLE
//   DATA  | voting and shifting 8 data bits, LSB first
//   STOP  | voting on stop bit; decide one cycle after tick 10, then IDLE
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50000000
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       uart_rx,
    input  logic [2:0] baud_set,
    output logic [7:0] Data,
    output logic       rx_done,
    output logic       frame_err
);

    rx_state_t  r_state;
    logic       r_sync1, r_sync2, r_sync3;
    logic [3:0] r_tick_idx;
    logic [2:0] r_bit_idx;
    logic [2:0] r_votes;
    logic [7:0] r_shift;
    logic [7:0] r_data;
    logic       r_rx_done, r_frame_err;
    logic       r_stop_bit, r_decide;

    logic       w_start, w_tick, w_restart, w_vote_win, w_maj;
    logic [2:0] w_ones;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_sync3 <= 1'b1;
        end else begin
            r_sync1 <= uart_rx;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_start    = r_sync3 & ~r_sync2;
    assign w_restart  = (r_state == ST_IDLE) && w_start;
    assign w_vote_win = (r_tick_idx >= 4'd6) && (r_tick_idx <= 4'd9);
    // Tick 10 is the fifth sample, so it joins the vote combinationally.
    assign w_ones     = r_votes + {2'b00, r_sync2};
    assign w_maj      = (w_ones >= 3'd3);

    uart_rx_tick_gen #(.CLK_FREQ(CLK_FREQ)) u_tick_gen (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .i_restart  (w_restart),
        .i_baud_set (baud_set),
        .o_tick     (w_tick)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= ST_IDLE;
            r_tick_idx  <= '0;
            r_bit_idx   <= '0;
            r_votes     <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_rx_done   <= 1'b0;
            r_frame_err <= 1'b0;
            r_stop_bit  <= 1'b0;
            r_decide    <= 1'b0;
        end else begin
            r_rx_done   <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state    <= ST_START;
                        r_tick_idx <= '0;
                        r_bit_idx  <= '0;
                        r_votes    <= '0;
                    end
                end
                ST_START, ST_DATA: begin
                    if (w_tick) begin
                        r_tick_idx <= r_tick_idx + 4'd1;
                        if (w_vote_win)
                            r_votes <= w_ones;
                        if (r_tick_idx == 4'd10) begin
                            r_votes <= '0;
                            if (r_state == ST_START && w_maj)
                                r_state <= ST_IDLE;
                            if (r_state == ST_DATA)
                                r_shift <= {w_maj, r_shift[7:1]};
                        end
                        if (r_tick_idx == 4'd15) begin
                            if (r_state == ST_START) begin
                                r_state <= ST_DATA;
                            end else begin
                                r_bit_idx <= r_bit_idx + 3'd1;
                                if (r_bit_idx == 3'd7)
                                    r_state <= ST_STOP;
                            end
                        end
                    end
                end
                ST_STOP: begin
                    if (r_decide) begin
                        r_decide <= 1'b0;
                        r_state  <= ST_IDLE;
                        if (r_stop_bit) begin
                            r_data    <= r_shift;
                            r_rx_done <= 1'b1;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end else if (w_tick) begin
                        r_tick_idx <= r_tick_idx + 4'd1;
                        if (w_vote_win)
                            r_votes <= w_ones;
                        if (r_tick_idx == 4'd10) begin
                            r_votes    <= '0;
                            r_stop_bit <= w_maj;
                            r_decide   <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign Data      = r_data;
    assign rx_done   = r_rx_done;
    assign frame_err = r_frame_err;

endmodule

// File: doc/uart_byte_rx.md
UART_BYTE_RX -- requirements
Module: uart_byte_rx

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, meaning system clock frequency in Hz.
REQ-002 Clk  input  1  system clock; all logic on rising edge.
REQ-003 Reset_n  input  1  reset, asynchronous, active-low.
REQ-004 uart_rx  input  1  asynchronous serial line; idle high; 8N1 framing, LSB first.
REQ-005 baud_set  input  3  rate select: 0=9600, 1=19200, 2=38400, 3=57600, 4=115200, 5..7=115200.
REQ-006 Data  output  8  last correctly received byte; holds its value until the next good frame.
REQ-007 rx_done  output  1  one-Clk pulse; Data updated in the same cycle.
REQ-008 frame_err  output  1  one-Clk pulse; stop bit sampled low; Data unchanged.

Function
REQ-009 uart_rx SHALL pass through a 2-flop synchronizer, plus a third flop for edge detect; a start is a synchronized 1->0 transition.
REQ-010 Oversample tick SHALL be 16x baud: period DIV = floor(CLK_FREQ/(16*baud)) Clk cycles (50 MHz: 325, 162, 81, 54, 27); tick counter reloads on start detect.
REQ-011 baud_set SHALL be latched at start detect; changes mid-frame SHALL have no effect until the next frame.
REQ-012 FSM states IDLE, START, DATA, STOP; reset state IDLE.
REQ-013 IDLE->START on start detect; start detect is ignored in all other states.
REQ-014 Each bit SHALL span 16 ticks (index 0..15); samples taken at ticks 6,7,8,9,10; bit value = majority (>=3 of 5).
REQ-015 START: majority 1 (glitch) -> IDLE, no output pulse; majority 0 -> DATA after tick 15.
REQ-016 DATA: 8 bits shifted LSB first into an internal shift register; -> STOP after tick 15 of bit 7.
REQ-017 STOP: decision made on the Clk following the tick-10 sample; stop=1 -> Data<=shift register, rx_done=1; stop=0 -> frame_err=1; both cases -> IDLE in that same cycle.
REQ-018 Early return (tick 10 of stop) SHALL allow a start edge from the very next cycle, so back-to-back frames are received without loss.
REQ-019 rx_done and frame_err SHALL never both be 1; each is high for exactly one Clk per frame.
REQ-020 Tick/bit/sample counters SHALL be wide enough for DIV=325 without wrap (9-bit tick-divider, 4-bit tick index, 3-bit bit index, 3-bit vote count).

Reset
REQ-021 On Reset_n low: FSM=IDLE, Data=8'h00, rx_done=0, frame_err=0, all counters 0, synchronizer flops=1 (idle high, no false edge on release).
REQ-022 Reset asserted mid-frame SHALL abort the frame without any pulse; reception resumes at the next start edge after release.

Structure
REQ-023 Shared package uart_pkg SHALL hold the baud-rate table (index->bps), the FSM state encoding and the oversample factor 16; uart_byte_tx uses the same table.
REQ-024 One sub-module, uart_rx_tick_gen (latched baud_set -> 16x tick strobe, restartable), SHALL be instantiated; voting and FSM stay in uart_byte_rx.

Verification
REQ-025 baud_set=4, 50 MHz, drive 0x55 at 115200 -> rx_done pulse once, Data=8'h55, frame_err=0.
REQ-026 Loopback from uart_byte_tx (baud_set=4) sending 0x00..0xFF back-to-back -> 256 rx_done pulses, Data equal to each sent byte in order, no frame_err.
REQ-027 Low glitch of 3 bit-times/16 on idle line -> FSM returns to IDLE, no rx_done/frame_err, Data unchanged.
REQ-028 Frame 0xA3 with stop bit forced low -> frame_err single pulse, rx_done=0, Data retains previous 8'h55.
REQ-029 baud_set=0, 9600, byte 0x3C with a 1-Clk inverted glitch at the centre of bit 2 -> majority vote rejects glitch, Data=8'h3C.
REQ-030 Reset_n pulsed low during bit 4 of 0xF0, then valid 0x0F sent -> no pulse for aborted frame, Data=8'h00 after reset, then Data=8'h0F with rx_done.
